// File: rtl/gac_pkt_gen.sv
// Localbus-programmed burst generator feeding scm: emits MD/PHV pairs framed by sent_start/sent_end pulses.
// Optional GAC_TIMESTAMP_EN: a free-running cycle counter stamps md[63:32] on every write.
module gac_pkt_gen #(
  parameter logic [7:0]  LMID      = 8'd7,
  parameter logic [7:0]  SMID      = 8'd6,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0100
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [255:0]  out_gac_md,
  output logic          out_gac_md_wr,
  input  logic          in_gac_md_alf,
  output logic [1023:0] out_gac_phv,
  output logic          out_gac_phv_wr,
  input  logic          in_gac_phv_alf,
  output logic          gac2scm_sent_start,
  output logic          gac2scm_sent_end,
  input  logic          cfg2gac_cs_n,
  output logic          gac2cfg_ack_n,
  input  logic          cfg2gac_rw,
  input  logic [31:0]   cfg2gac_addr,
  input  logic [31:0]   cfg2gac_wdata,
  output logic [31:0]   gac2cfg_rdata
);

  localparam logic [31:0] A_CTRL     = BASE_ADDR + 32'h00;
  localparam logic [31:0] A_PKT_NUM  = BASE_ADDR + 32'h04;
  localparam logic [31:0] A_GAP      = BASE_ADDR + 32'h08;
  localparam logic [31:0] A_STATUS   = BASE_ADDR + 32'h0C;
  localparam logic [31:0] A_SENT_CNT = BASE_ADDR + 32'h10;
  localparam logic [31:0] A_PATTERN  = BASE_ADDR + 32'h14;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_SEND,
    ST_GAP,
    ST_END
  } state_t;

  state_t      state;
  logic [31:0] pkt_num;
  logic [31:0] gap;
  logic [31:0] pattern;
  logic [31:0] sent_cnt;
  logic [31:0] gap_cnt;
  logic        aborted;
  logic        start_req;
  logic        abort_req;
  logic        busy;
  logic        active;
  logic        can_send;
  logic        go_send;
  logic [31:0] stamp;

  assign busy     = (state != ST_IDLE);
  assign active   = (state == ST_START) || (state == ST_SEND) || (state == ST_GAP);
  assign can_send = (sent_cnt < pkt_num) && !in_gac_md_alf && !in_gac_phv_alf;

`ifdef GAC_TIMESTAMP_EN
  logic [31:0] ts_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts_cnt <= '0;
    else        ts_cnt <= ts_cnt + 32'd1;
  end

  assign stamp = ts_cnt;
`else
  assign stamp = '0;
`endif

  // Localbus: one access per cs_n assertion, ack_n low from the cycle after cs_n
  // is first sampled low until the cycle after cs_n is sampled high again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gac2cfg_ack_n <= 1'b1;
      gac2cfg_rdata <= '0;
      pkt_num       <= '0;
      gap           <= '0;
      pattern       <= '0;
      start_req     <= 1'b0;
      abort_req     <= 1'b0;
    end else begin
      start_req <= 1'b0;
      abort_req <= 1'b0;
      if (cfg2gac_cs_n) begin
        gac2cfg_ack_n <= 1'b1;
      end else if (gac2cfg_ack_n) begin
        gac2cfg_ack_n <= 1'b0;
        if (cfg2gac_rw) begin
          case (cfg2gac_addr)
            A_CTRL:     gac2cfg_rdata <= '0;
            A_PKT_NUM:  gac2cfg_rdata <= pkt_num;
            A_GAP:      gac2cfg_rdata <= gap;
            A_STATUS:   gac2cfg_rdata <= {30'd0, aborted, busy};
            A_SENT_CNT: gac2cfg_rdata <= sent_cnt;
            A_PATTERN:  gac2cfg_rdata <= pattern;
            default:    gac2cfg_rdata <= 32'hDEAD_BEEF;
          endcase
        end else begin
          case (cfg2gac_addr)
            A_CTRL: begin
              start_req <= cfg2gac_wdata[0];
              abort_req <= cfg2gac_wdata[1];
            end
            A_PKT_NUM: pkt_num <= cfg2gac_wdata;
            A_GAP:     gap     <= cfg2gac_wdata;
            A_PATTERN: pattern <= cfg2gac_wdata;
            default: ;
          endcase
        end
      end
    end
  end

  // Decides whether the next cycle is a SEND cycle; the write itself is
  // registered so the strobe lands in that SEND cycle.
  always_comb begin
    go_send = 1'b0;
    case (state)
      ST_START: go_send = 1'b1;
      ST_SEND:  go_send = out_gac_md_wr ? (gap == 32'd0) : (sent_cnt < pkt_num);
      ST_GAP:   go_send = (gap_cnt == 32'd0);
      default:  go_send = 1'b0;
    endcase
    if (abort_req) go_send = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= ST_IDLE;
      sent_cnt           <= '0;
      gap_cnt            <= '0;
      aborted            <= 1'b0;
      out_gac_md         <= '0;
      out_gac_md_wr      <= 1'b0;
      out_gac_phv        <= '0;
      out_gac_phv_wr     <= 1'b0;
      gac2scm_sent_start <= 1'b0;
      gac2scm_sent_end   <= 1'b0;
    end else begin
      gac2scm_sent_start <= 1'b0;
      gac2scm_sent_end   <= 1'b0;
      out_gac_md_wr      <= 1'b0;
      out_gac_phv_wr     <= 1'b0;

      if (active && abort_req) begin
        state            <= ST_END;
        gac2scm_sent_end <= 1'b1;
        aborted          <= 1'b1;
      end else if (go_send) begin
        state <= ST_SEND;
        if (can_send) begin
          out_gac_md_wr  <= 1'b1;
          out_gac_phv_wr <= 1'b1;
          out_gac_md     <= {160'd0, SMID, LMID, 16'd0, stamp, sent_cnt};
          out_gac_phv    <= {sent_cnt, {31{pattern}}};
          if (sent_cnt != 32'hFFFF_FFFF) sent_cnt <= sent_cnt + 32'd1;
        end
      end else begin
        case (state)
          ST_IDLE: begin
            if (start_req) begin
              state              <= ST_START;
              gac2scm_sent_start <= 1'b1;
              sent_cnt           <= '0;
              aborted            <= 1'b0;
            end
          end
          ST_SEND: begin
            if (out_gac_md_wr) begin
              state   <= ST_GAP;
              gap_cnt <= gap - 32'd1;
            end else begin
              state            <= ST_END;
              gac2scm_sent_end <= 1'b1;
            end
          end
          ST_GAP:  gap_cnt <= gap_cnt - 32'd1;
          ST_END:  state   <= ST_IDLE;
          default: state   <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
